// File: rtl/ar_rxd_mk2_pkg.sv
// Shared types and constants for the ARINC-429 receiver slice.
package ar429_pkg;

  localparam int unsigned LABEL_W   = 8;
  localparam int unsigned DATA_W    = 23;
  localparam int unsigned WORD_BITS = 32;

  // One received word as queued for the host.
  typedef struct packed {
    logic               par_err;
    logic [LABEL_W-1:0] adr;
    logic [DATA_W-1:0]  dat;
  } ar429_word_t;

  // Outcome of a word when the inter-word gap closes it.
  typedef enum logic [1:0] {
    CLOSE_NONE,
    CLOSE_ACCEPT,
    CLOSE_REJECT,
    CLOSE_FRAME_ERR
  } close_t;

  // Odd parity over label, data and parity bit: error when the XOR is 0.
  function automatic logic odd_par_err(input logic [LABEL_W-1:0] adr,
                                       input logic [DATA_W:0]    dat);
    return ~(^{adr, dat});
  endfunction

endpackage

// File: rtl/ar_rxd_mk2_if.sv
// Host-side word interface of the ARINC-429 receiver.
interface ar_rxd_mk2_if;
  import ar429_pkg::*;

  logic               flt_en;
  logic [LABEL_W-1:0] flt_label;
  logic               rd_en;
  logic [LABEL_W-1:0] rd_adr;
  logic [DATA_W-1:0]  rd_dat;
  logic               rd_par_err;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               ovf_clr;
  logic [7:0]         frm_err_cnt;

  modport master (
    output flt_en, flt_label, rd_en, ovf_clr,
    input  rd_adr, rd_dat, rd_par_err, empty, full, ovf, frm_err_cnt
  );

  modport slave (
    input  flt_en, flt_label, rd_en, ovf_clr,
    output rd_adr, rd_dat, rd_par_err, empty, full, ovf, frm_err_cnt
  );

endinterface

// File: rtl/ar_rxd_mk2_fifo.sv
// First-word-fall-through FIFO of received words; head reads as 0 when empty.
module ar_rxd_fifo
  import ar429_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  ar429_word_t wr_word,
  input  logic        pop,
  output ar429_word_t rd_word,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ar429_word_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  // Pop only a present word; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_rd   = pop & ~empty;
    do_wr   = push & (~full | do_rd);
    rd_word = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage; contents are masked by empty so need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_word;
  end

endmodule

// File: rtl/ar_rxd_mk2.sv
// ARINC-429 bipolar line receiver: synchroniser, bit framer, gap timer,
// parity/label checks, overflow flag and frame-error counter feeding a word FIFO.
module ar_rxd_mk2
  import ar429_pkg::*;
#(
  parameter int unsigned GAP_CYC     = 1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RXD0,
  input  logic         RXD1,
  ar_rxd_mk2_if.slave  host
);

  localparam int unsigned     GW        = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0]   GAP_MAX   = GW'(GAP_CYC);
  localparam logic [5:0]      CNT_LABEL = 6'(LABEL_W);
  localparam logic [5:0]      CNT_WORD  = 6'(WORD_BITS);
  localparam logic [5:0]      CNT_LONG  = 6'(WORD_BITS + 1);

  logic [SYNC_STAGES-1:0] sync0_q;
  logic [SYNC_STAGES-1:0] sync1_q;
  logic                   s0;
  logic                   s1;
  logic                   qm;
  logic                   qm_prev;
  logic                   strobe;
  logic                   fault_now;

  logic [GW-1:0]          gap_cnt;
  logic [5:0]             bit_cnt;
  logic [5:0]             eff_cnt;
  logic [5:0]             bit_cnt_nxt;
  logic                   line_fault;
  logic                   line_fault_nxt;
  logic                   long_word;
  logic                   long_word_nxt;
  logic                   close;

  logic [LABEL_W-1:0]     adr;
  logic [DATA_W:0]        dat;

  close_t                 verdict;
  logic                   push_req;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  ar429_word_t            wr_word;
  ar429_word_t            rd_word;
  logic                   ovf;
  logic [7:0]             frm_err_cnt;

  // Input synchronisers and previous QM for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
      qm_prev <= 1'b0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], RXD0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], RXD1};
      qm_prev <= qm;
    end
  end

  // Framer next-state; a strobe landing on the close cycle starts the next word,
  // so per-word state is taken as already cleared (eff_cnt) before the strobe applies.
  always_comb begin
    s0     = sync0_q[SYNC_STAGES-1];
    s1     = sync1_q[SYNC_STAGES-1];
    qm     = s0 | s1;
    strobe = qm & ~qm_prev;
    close  = (gap_cnt == GAP_MAX) && (bit_cnt != '0);

    eff_cnt     = close ? '0 : bit_cnt;
    bit_cnt_nxt = eff_cnt;
    if (strobe && (eff_cnt != CNT_LONG)) bit_cnt_nxt = eff_cnt + 6'd1;

    long_word_nxt = close ? 1'b0 : long_word;
    if (strobe && (eff_cnt >= CNT_WORD)) long_word_nxt = 1'b1;

    fault_now      = s0 & s1 & (strobe | (eff_cnt != '0));
    line_fault_nxt = (close ? 1'b0 : line_fault) | fault_now;

    if (!close)
      verdict = CLOSE_NONE;
    else if ((bit_cnt != CNT_WORD) || line_fault || long_word)
      verdict = CLOSE_FRAME_ERR;
    else if (!host.flt_en || (adr == host.flt_label))
      verdict = CLOSE_ACCEPT;
    else
      verdict = CLOSE_REJECT;

    push_req        = (verdict == CLOSE_ACCEPT);
    fifo_push       = push_req & (~fifo_full | host.rd_en);
    wr_word.par_err = odd_par_err(adr, dat);
    wr_word.adr     = adr;
    wr_word.dat     = dat[DATA_W-1:0];
  end

  // Bit counter, word flags, gap timer and label/data shifters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      line_fault <= 1'b0;
      long_word  <= 1'b0;
      adr        <= '0;
      dat        <= '0;
    end else begin
      if (qm) gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
      bit_cnt    <= bit_cnt_nxt;
      line_fault <= line_fault_nxt;
      long_word  <= long_word_nxt;
      if (strobe) begin
        if (eff_cnt < CNT_LABEL) adr <= {adr[LABEL_W-2:0], s1};
        else if (eff_cnt < CNT_WORD) dat <= {s1, dat[DATA_W:1]};
      end
    end
  end

  // Sticky overflow (set wins over clear) and saturating frame-error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf         <= 1'b0;
      frm_err_cnt <= '0;
    end else begin
      if (push_req && fifo_full && !host.rd_en) ovf <= 1'b1;
      else if (host.ovf_clr) ovf <= 1'b0;
      if ((verdict == CLOSE_FRAME_ERR) && (frm_err_cnt != 8'hFF))
        frm_err_cnt <= frm_err_cnt + 8'd1;
    end
  end

  ar_rxd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_word (wr_word),
    .pop     (host.rd_en),
    .rd_word (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Host-facing outputs.
  always_comb begin
    host.rd_adr      = rd_word.adr;
    host.rd_dat      = rd_word.dat;
    host.rd_par_err  = rd_word.par_err;
    host.empty       = fifo_empty;
    host.full        = fifo_full;
    host.ovf         = ovf;
    host.frm_err_cnt = frm_err_cnt;
  end

endmodule

// File: tb/tb_ar_rxd_mk2.sv
// Self-checking bench for ar_rxd_mk2 with a queue-based reference model.
module tb_ar_rxd_mk2;
  import ar429_pkg::*;

  localparam int unsigned GAP   = 16;
  localparam int unsigned DEPTH = 8;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic RXD0 = 1'b0;
  logic RXD1 = 1'b0;

  ar_rxd_mk2_if host ();

  ar_rxd_mk2 #(
    .GAP_CYC     (GAP),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .RXD0 (RXD0),
    .RXD1 (RXD1),
    .host (host)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  adr;
    logic [22:0] dat;
    logic        par_err;
  } exp_t;

  exp_t q[$];
  int   m_err;
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 0;
    m_ovf = 0;
  endtask

  // Transmit a word: label MSB first, data LSB first, then parity (odd unless flipped).
  task automatic send_word(input logic [7:0] adr, input logic [22:0] dat, input bit flip,
                           input int nbits, input int fault_bit, input bit abort);
    logic [32:0] bits;
    logic        par;
    par = ~(^{adr, dat}) ^ flip;
    for (int i = 0; i < 8; i++)  bits[i] = adr[7-i];
    for (int i = 0; i < 23; i++) bits[8+i] = dat[i];
    bits[31] = par;
    bits[32] = 1'($urandom_range(0, 1));
    for (int i = 0; i < nbits; i++) begin
      repeat (4) begin
        RXD1 = (i == fault_bit) ? 1'b1 : bits[i];
        RXD0 = (i == fault_bit) ? 1'b1 : ~bits[i];
        step();
      end
      RXD0 = 1'b0;
      RXD1 = 1'b0;
      repeat (4) step();
    end
    if (!abort) begin
      repeat (GAP + 6) step();
      if (nbits == 32 && fault_bit < 0) begin
        if (!host.flt_en || adr == host.flt_label) begin
          if (q.size() < DEPTH) q.push_back('{adr, dat, flip});
          else m_ovf = 1;
        end
      end else if (m_err < 255) begin
        m_err++;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_empty"}, 32'(host.empty), 32'(q.size() == 0));
    check({tag, "_full"},  32'(host.full),  32'(q.size() == DEPTH));
    check({tag, "_ovf"},   32'(host.ovf),   32'(m_ovf));
    check({tag, "_frm"},   32'(host.frm_err_cnt), 32'(m_err));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = q.pop_front();
    check({tag, "_adr"}, 32'(host.rd_adr), 32'(e.adr));
    check({tag, "_dat"}, 32'(host.rd_dat), 32'(e.dat));
    check({tag, "_par"}, 32'(host.rd_par_err), 32'(e.par_err));
    host.rd_en = 1'b1;
    step();
    host.rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_check(tag);
    step();
    check({tag, "_drained"}, 32'(host.empty), 32'd1);
  endtask

  initial begin
    logic [7:0]  la;
    logic [22:0] da;
    int          r;
    int          nb;
    int          fb;

    host.flt_en    = 1'b0;
    host.flt_label = 8'h00;
    host.rd_en     = 1'b0;
    host.ovf_clr   = 1'b0;
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    check("rst_empty", 32'(host.empty), 32'd1);
    check("rst_full", 32'(host.full), 32'd0);
    check("rst_ovf", 32'(host.ovf), 32'd0);
    check("rst_frm", 32'(host.frm_err_cnt), 32'd0);
    check("rst_adr", 32'(host.rd_adr), 32'd0);
    check("rst_dat", 32'(host.rd_dat), 32'd0);
    check("rst_par", 32'(host.rd_par_err), 32'd0);

    // Clean word
    send_word(8'hA5, 23'h12345, 1'b0, 32, -1, 1'b0);
    check_status("t1");
    check("t1_adr_lit", 32'(host.rd_adr), 32'h0A5);
    check("t1_dat_lit", 32'(host.rd_dat), 32'h12345);
    check("t1_par_lit", 32'(host.rd_par_err), 32'd0);
    drain("t1");

    // Parity flipped
    send_word(8'hA5, 23'h12345, 1'b1, 32, -1, 1'b0);
    check_status("t2");
    check("t2_par_lit", 32'(host.rd_par_err), 32'd1);
    check("t2_frm_lit", 32'(host.frm_err_cnt), 32'd0);
    drain("t2");

    // Short and long words
    send_word(8'h11, 23'h2AAAA, 1'b0, 31, -1, 1'b0);
    send_word(8'h22, 23'h15555, 1'b0, 33, -1, 1'b0);
    check_status("t3");
    check("t3_frm_lit", 32'(host.frm_err_cnt), 32'd2);

    // Label filter
    host.flt_en    = 1'b1;
    host.flt_label = 8'hA5;
    send_word(8'h3C, 23'h00777, 1'b0, 32, -1, 1'b0);
    send_word(8'hA5, 23'h7FFFF, 1'b0, 32, -1, 1'b0);
    check_status("t4");
    check("t4_adr_lit", 32'(host.rd_adr), 32'h0A5);
    drain("t4");
    host.flt_en = 1'b0;

    // Overflow: 9 words into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      send_word(8'($urandom), 23'($urandom), 1'($urandom_range(0, 1)), 32, -1, 1'b0);
      if (i == 7) check("t5_full8", 32'(host.full), 32'd1);
    end
    check_status("t5");
    check("t5_ovf_lit", 32'(host.ovf), 32'd1);
    host.ovf_clr = 1'b1;
    step();
    host.ovf_clr = 1'b0;
    m_ovf = 0;
    step();
    check("t5_ovf_clr", 32'(host.ovf), 32'd0);
    drain("t5");

    // Line fault inside a word
    send_word(8'h5A, 23'h0F0F0, 1'b0, 32, 12, 1'b0);
    check_status("lf");

    // Randomised words, filter settings and framing faults
    for (int i = 0; i < 12; i++) begin
      host.flt_en    = 1'($urandom_range(0, 1));
      host.flt_label = 8'($urandom);
      la = ($urandom_range(0, 1) == 1) ? host.flt_label : 8'($urandom);
      da = 23'($urandom);
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? 31 : (r == 1) ? 33 : 32;
      fb = (r == 2) ? $urandom_range(0, 31) : -1;
      send_word(la, da, 1'($urandom_range(0, 1)), nb, fb, 1'b0);
      check_status("rnd");
      drain("rnd");
    end
    host.flt_en = 1'b0;

    // Reset mid-word, then a clean word
    send_word(8'hC3, 23'h3C3C3, 1'b0, 20, -1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    repeat (GAP + 6) step();
    send_word(8'h81, 23'h40001, 1'b0, 32, -1, 1'b0);
    check_status("t6");
    check("t6_frm_lit", 32'(host.frm_err_cnt), 32'd0);
    check("t6_adr_lit", 32'(host.rd_adr), 32'h081);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
